sub_bytes_pipe: RTL and testbench
=================================

// Module: sub_bytes_pipe
// PURPOSE
//  Parametrised, pipelined AES byte-substitution engine for the encrypt and decrypt round datapaths.
//  Applies the forward S-box (mode=0) or the inverse S-box (mode=1) to LANES bytes per beat.
//  Mode is carried per beat. Uses a valid/ready handshake with full backpressure.
//  Keeps a wrapping count of completed beats for debug and verification.
// PARAMETERS
//  LANES   4   bytes substituted per beat (1..16; 16 = one full AES state)
//  STAGES  2   pipeline register stages between input and output (1..3)
//  CNT_W   16  width of the completed-beat counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  flush      in   1          synchronous clear of all pipeline valids; counter is not affected
//  in_valid   in   1          input beat valid
//  in_ready   out  1          engine accepts a beat this cycle
//  in_mode    in   1          0 = forward S-box, 1 = inverse S-box
//  in_data    in   [0:8*LANES-1]  lane k occupies bits [8k:8k+7], bit 8k is the byte MSB
//  out_valid  out  1          output beat valid
//  out_ready  in   1          downstream accepts output beat
//  out_mode   out  1          mode of the beat on out_data
//  out_data   out  [0:8*LANES-1]  substituted bytes, same lane order as the input
//  beat_cnt   out  CNT_W      number of output handshakes since reset, modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync release):
//    - all stage valids = 0, so out_valid = 0
//    - out_data = 0, out_mode = 0, beat_cnt = 0
//    - in_ready = 1 on the first cycle after release
//  - Pipeline has STAGES slots s[0..STAGES-1], each holding {valid, mode, data}.
//    - Lookup is combinational between the input and s[0].
//    - The forward table is the FIPS-197 S-box; the inverse table is its exact inverse.
//    - Later stages copy the slot contents unchanged.
//    - out_* is driven from s[STAGES-1].
//  - Advance rule, evaluated combinationally from the output back to the input:
//    - adv[STAGES-1] = ~s[STAGES-1].valid | out_ready
//    - adv[k] = ~s[k].valid | adv[k+1]
//    - in_ready = adv[0]
//    - No bubbles: a full pipe with out_ready=1 accepts one beat every cycle.
//  - Latency:
//    - A beat accepted at edge t appears on out_valid after edge t+STAGES-1 when unstalled.
//    - In-to-out throughput is 1 beat per cycle.
//  - Stall:
//    - While out_valid=1 and out_ready=0, out_data and out_mode hold stable.
//    - An upstream slot only loads when its successor frees.
//  - Input loads:
//    - in_valid & in_ready loads s[0].
//    - in_valid & ~in_ready: nothing is captured, and upstream must hold the beat.
//  - Counter:
//    - beat_cnt increments on each out_valid & out_ready; 2^CNT_W-1 wraps to 0.
//  - Flush:
//    - flush=1 clears every slot valid at the next edge; a concurrent input beat is dropped.
//    - in_ready is forced to 0 during the flush cycle.
//    - An out handshake in the flush cycle still counts.
//  - Mode:
//    - Mode may differ on every consecutive beat with no penalty.
//    - Beats never reorder.
//  - Reset mid-operation:
//    - All in-flight beats are discarded; outputs take their reset values immediately (async).
//  - Invalid slots:
//    - Data in invalid slots is don't-care internally.
//    - out_data is only checked while out_valid=1.
// TESTING
//  - Fwd single lane: LANES=4, mode=0, in=00_01_53_ff -> out=63_7c_ed_16 after STAGES cycles.
//  - Inv single lane: mode=1, in=63_00_ff_ed -> out=00_52_7d_53.
//  - Round trip: all 256 byte values forward, result fed back with mode=1 -> identity.
//    - Also alternate modes on every beat; check order is kept.
//  - Backpressure: out_ready low for 5 cycles with continuous in_valid.
//    - in_ready drops after STAGES accepted beats; out_data stays stable.
//    - Release out_ready -> no loss, no duplication, back-to-back output.
//  - Flush/reset: flush with 2 beats in flight -> out_valid=0 next cycle, beat_cnt unchanged.
//    - rst_n pulse mid-stream -> all outputs 0 asynchronously.
//  - Counter wrap: CNT_W=4, 17 handshakes -> beat_cnt=1.
//    - Random valid/ready over LANES in {1,16} and STAGES in {1,3} matches the reference model.

Source files
------------

// File: rtl/sub_bytes_pipe_if.sv
// Handshake bundle for the AES byte-substitution engine.
// The engine connects through "slave"; the upstream/downstream driver uses "master".
interface sub_bytes_pipe_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [0:8*LANES-1]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_mode;
  logic [0:8*LANES-1]   out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );
endinterface

// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine.
// LANES bytes are substituted combinationally into the first slot; later slots
// only copy. Each slot advances when it is empty or its successor advances, so a
// full pipe with a ready sink streams one beat per cycle without bubbles.
module sub_bytes_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  sub_bytes_pipe_if.slave  bus,
  output logic [CNT_W-1:0] beat_cnt
);
  localparam int DW = 8 * LANES;

  // Forward S-box built at elaboration: walk GF(2^8)* with generator 3 (p)
  // while q tracks 1/p, then apply the AES affine transform to q.
  function automatic logic [2047:0] build_fwd();
    logic [7:0]    p;
    logic [7:0]    q;
    logic [7:0]    x;
    logic [2047:0] t;
    t = '0;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      t[{p, 3'b000} +: 8] = x ^ 8'h63;
    end
    // zero has no multiplicative inverse; its entry is the affine constant
    t[7:0] = 8'h63;
    return t;
  endfunction

  // Inverse S-box is the permutation inverse of the forward table.
  function automatic logic [2047:0] build_inv(input logic [2047:0] fwd);
    logic [2047:0] t;
    logic [7:0]    v;
    logic [7:0]    idx;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      v   = fwd[{idx, 3'b000} +: 8];
      t[{v, 3'b000} +: 8] = idx;
    end
    return t;
  endfunction

  localparam logic [2047:0] FWD_TAB = build_fwd();
  localparam logic [2047:0] INV_TAB = build_inv(FWD_TAB);

  logic [0:DW-1]     sub_data;
  logic              slot_valid [STAGES];
  logic              slot_mode  [STAGES];
  logic [0:DW-1]     slot_data  [STAGES];
  logic [STAGES-1:0] adv;
  logic              adv_carry;

  genvar gi;

  // Per-lane table lookup; bit 8k of a lane is the byte MSB.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] in_byte;
      assign in_byte = bus.in_data[8*gi +: 8];
      assign sub_data[8*gi +: 8] = bus.in_mode ? INV_TAB[{in_byte, 3'b000} +: 8]
                                               : FWD_TAB[{in_byte, 3'b000} +: 8];
    end
  endgenerate

  // Advance enables, resolved from the output slot back toward the input.
  always_comb begin
    adv       = '0;
    adv_carry = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_carry = ~slot_valid[k] | adv_carry;
      adv[k]    = adv_carry;
    end
  end

  assign bus.in_ready  = adv[0] & ~flush;
  assign bus.out_valid = slot_valid[STAGES-1];
  assign bus.out_mode  = slot_mode[STAGES-1];
  assign bus.out_data  = slot_data[STAGES-1];

  // Slot registers: load substituted input into slot 0, shift the rest forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        slot_valid[k] <= 1'b0;
        slot_mode[k]  <= 1'b0;
        slot_data[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        slot_valid[k] <= 1'b0;
      end
    end else begin
      if (adv[0]) begin
        slot_valid[0] <= bus.in_valid;
        slot_mode[0]  <= bus.in_mode;
        slot_data[0]  <= sub_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          slot_valid[k] <= slot_valid[k-1];
          slot_mode[k]  <= slot_mode[k-1];
          slot_data[k]  <= slot_data[k-1];
        end
      end
    end
  end

  // Completed-beat counter; counts output handshakes even in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: directed cases on a 4-lane/2-stage instance with a
// 4-bit counter, then randomized traffic on 16-lane/3-stage and 1-lane/1-stage
// instances scored against a GF(2^8) reference model.
module tb_sub_bytes_pipe;
  localparam int ST_A = 2;
  localparam int ST_B = 3;
  localparam int ST_C = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush_a, flush_b, flush_c;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [7:0]  cnt_c;

  sub_bytes_pipe_if #(.LANES(4))  bus_a ();
  sub_bytes_pipe_if #(.LANES(16)) bus_b ();
  sub_bytes_pipe_if #(.LANES(1))  bus_c ();

  sub_bytes_pipe #(.LANES(4), .STAGES(ST_A), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a), .beat_cnt(cnt_a));
  sub_bytes_pipe #(.LANES(16), .STAGES(ST_B), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b), .beat_cnt(cnt_b));
  sub_bytes_pipe #(.LANES(1), .STAGES(ST_C), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .bus(bus_c), .beat_cnt(cnt_c));

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt_a = 0;

  logic [7:0]  sbox  [256];
  logic [7:0]  isbox [256];
  logic [32:0] src_q [$];
  logic [32:0] res_q [$];
  logic [32:0] last_out_a;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [7:0] a;
    r = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // S-box from its definition: brute-force multiplicative inverse, then affine map.
  task automatic build_tables();
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
        end
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      end
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [0:127] sub_ref(input logic mode, input logic [0:127] d, input int lanes);
    logic [0:127] r;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      r[8*k +: 8] = mode ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
    end
    return r;
  endfunction

  function automatic logic [32:0] ref_a(input logic [32:0] beat);
    logic [0:31]  d;
    logic [0:127] r;
    d = beat[31:0];
    r = sub_ref(beat[32], {d, 96'h0}, 4);
    return {beat[32], r[0:31]};
  endfunction

  // Streams src_q through dut_a; out_ready is held low for the first 'stall' cycles.
  task automatic stream_a(input int stall, input string tag);
    int sent;
    int cyc;
    int first;
    logic [32:0] exp_e;
    sent  = 0;
    cyc   = 0;
    first = -1;
    res_q.delete();
    while (res_q.size() < src_q.size() && cyc < 600) begin
      bus_a.in_valid = (sent < src_q.size());
      if (sent < src_q.size()) {bus_a.in_mode, bus_a.in_data} = src_q[sent];
      bus_a.out_ready = (cyc >= stall);
      #1;
      if (cyc < stall)
        check({tag, " in_ready_stall"}, 136'(bus_a.in_ready), 136'(cyc < ST_A));
      if (stall > 0 && cyc >= stall)
        check({tag, " back_to_back"}, 136'(bus_a.out_valid), 136'(1'b1));
      if (bus_a.out_valid) begin
        exp_e = ref_a(src_q[res_q.size()]);
        if (!bus_a.out_ready) begin
          check({tag, " held_out"}, 136'({bus_a.out_mode, bus_a.out_data}), 136'(exp_e));
        end else begin
          check({tag, " out"}, 136'({bus_a.out_mode, bus_a.out_data}), 136'(exp_e));
          last_out_a = {bus_a.out_mode, bus_a.out_data};
          res_q.push_back(last_out_a);
          exp_cnt_a++;
          if (first < 0) first = cyc;
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    bus_a.in_valid = 1'b0;
    if (cyc >= 600) check({tag, " timeout"}, 136'(res_q.size()), 136'(src_q.size()));
    if (stall == 0) check({tag, " latency"}, 136'(first), 136'(ST_A));
    check({tag, " beat_cnt"}, 136'(cnt_a), 136'(exp_cnt_a[3:0]));
  endtask

  task automatic fill2_a();
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_mode  = 1'(i);
      bus_a.in_data  = $urandom();
      #1;
      check("fill in_ready", 136'(bus_a.in_ready), 136'(1'b1));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [128:0] qb [$];
    logic [8:0]   qc [$];
    logic [128:0] eb;
    logic [8:0]   ec;
    logic [0:127] rb;
    logic [0:127] dc;
    logic [0:7]   bc;
    logic [31:0]  word;
    int exp_cnt_b;
    int exp_cnt_c;

    rst_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_mode = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_mode = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;
    build_tables();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 136'(bus_a.out_valid), 136'(1'b0));
    check("rst out_data",  136'(bus_a.out_data),  136'(32'h0));
    check("rst out_mode",  136'(bus_a.out_mode),  136'(1'b0));
    check("rst beat_cnt",  136'(cnt_a),           136'(4'h0));
    check("rst b out_valid", 136'(bus_b.out_valid), 136'(1'b0));
    check("rst c beat_cnt",  136'(cnt_c),           136'(8'h0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel in_ready", 136'(bus_a.in_ready), 136'(1'b1));

    // known-answer vectors
    src_q = '{{1'b0, 32'h0001_53ff}};
    stream_a(0, "fwd");
    check("fwd vector", 136'(last_out_a), 136'({1'b0, 32'h637c_ed16}));
    src_q = '{{1'b1, 32'h6300_ffed}};
    stream_a(0, "inv");
    check("inv vector", 136'(last_out_a), 136'({1'b1, 32'h0052_7d53}));

    // round trip over all 256 byte values
    src_q.delete();
    for (int i = 0; i < 64; i++) src_q.push_back({1'b0, 8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    stream_a(0, "rt_fwd");
    src_q.delete();
    for (int i = 0; i < res_q.size(); i++) src_q.push_back({1'b1, res_q[i][31:0]});
    stream_a(0, "rt_inv");
    for (int i = 0; i < res_q.size(); i++)
      check("rt identity", 136'(res_q[i][31:0]), 136'({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}));

    // alternating modes every beat
    src_q.delete();
    for (int i = 0; i < 40; i++) src_q.push_back({1'(i), $urandom()});
    stream_a(0, "alt");

    // backpressure: out_ready low for 5 cycles with continuous input
    src_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back({1'($urandom()), $urandom()});
    stream_a(5, "bp");

    // flush with two beats in flight, sink stalled
    fill2_a();
    flush_a = 1'b1;
    bus_a.in_valid = 1'b1;
    #1;
    check("flush in_ready", 136'(bus_a.in_ready), 136'(1'b0));
    check("flush pre out_valid", 136'(bus_a.out_valid), 136'(1'b1));
    @(posedge clk); #1;
    flush_a = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    check("flush out_valid", 136'(bus_a.out_valid), 136'(1'b0));
    check("flush beat_cnt", 136'(cnt_a), 136'(exp_cnt_a[3:0]));
    @(posedge clk); #1;
    check("flush dropped", 136'(bus_a.out_valid), 136'(1'b0));

    // flush coinciding with an output handshake
    fill2_a();
    bus_a.in_valid = 1'b0;
    flush_a = 1'b1;
    bus_a.out_ready = 1'b1;
    #1;
    if (bus_a.out_valid) exp_cnt_a++;
    @(posedge clk); #1;
    flush_a = 1'b0;
    #1;
    check("flush hs beat_cnt", 136'(cnt_a), 136'(exp_cnt_a[3:0]));
    check("flush hs out_valid", 136'(bus_a.out_valid), 136'(1'b0));

    // asynchronous reset mid-stream
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_mode  = 1'b0;
      bus_a.in_data  = $urandom() | 32'h1;
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", 136'(bus_a.out_valid), 136'(1'b0));
    check("arst out_data",  136'(bus_a.out_data),  136'(32'h0));
    check("arst out_mode",  136'(bus_a.out_mode),  136'(1'b0));
    check("arst beat_cnt",  136'(cnt_a),           136'(4'h0));
    bus_a.in_valid = 1'b0;
    exp_cnt_a = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst in_ready", 136'(bus_a.in_ready), 136'(1'b1));

    // counter wrap: 17 handshakes on a 4-bit counter
    src_q.delete();
    for (int i = 0; i < 17; i++) src_q.push_back({1'($urandom()), $urandom()});
    stream_a(0, "wrap");
    check("wrap value", 136'(cnt_a), 136'(4'd1));

    // randomized traffic on the wide/deep and narrow/shallow instances
    exp_cnt_b = 0;
    exp_cnt_c = 0;
    bus_a.out_ready = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus_b.in_valid  = ($urandom_range(0, 99) < 70);
      bus_b.in_mode   = 1'($urandom());
      bus_b.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_b.out_ready = ($urandom_range(0, 99) < 60);
      flush_b         = ($urandom_range(0, 63) == 0);
      word            = $urandom();
      bus_c.in_valid  = ($urandom_range(0, 99) < 70);
      bus_c.in_mode   = word[8];
      bus_c.in_data   = word[7:0];
      bus_c.out_ready = ($urandom_range(0, 99) < 60);
      flush_c         = ($urandom_range(0, 63) == 0);
      #1;

      check("rnd b in_ready", 136'(bus_b.in_ready),
            136'(!flush_b && (qb.size() < ST_B || bus_b.out_ready)));
      if (qb.size() == 0) check("rnd b idle", 136'(bus_b.out_valid), 136'(1'b0));
      if (bus_b.out_valid && bus_b.out_ready) begin
        exp_cnt_b++;
        if (qb.size() == 0) check("rnd b extra beat", 136'(bus_b.out_valid), 136'(1'b0));
        else begin
          eb = qb.pop_front();
          check("rnd b out", 136'({bus_b.out_mode, bus_b.out_data}), 136'(eb));
        end
      end
      if (bus_b.in_valid && bus_b.in_ready) begin
        rb = sub_ref(bus_b.in_mode, bus_b.in_data, 16);
        qb.push_back({bus_b.in_mode, rb});
      end
      if (flush_b) qb.delete();

      check("rnd c in_ready", 136'(bus_c.in_ready),
            136'(!flush_c && (qc.size() < ST_C || bus_c.out_ready)));
      if (qc.size() == 0) check("rnd c idle", 136'(bus_c.out_valid), 136'(1'b0));
      if (bus_c.out_valid && bus_c.out_ready) begin
        exp_cnt_c++;
        if (qc.size() == 0) check("rnd c extra beat", 136'(bus_c.out_valid), 136'(1'b0));
        else begin
          ec = qc.pop_front();
          check("rnd c out", 136'({bus_c.out_mode, bus_c.out_data}), 136'(ec));
        end
      end
      if (bus_c.in_valid && bus_c.in_ready) begin
        bc = bus_c.in_data;
        dc = sub_ref(bus_c.in_mode, {bc, 120'h0}, 1);
        qc.push_back({bus_c.in_mode, dc[0:7]});
      end
      if (flush_c) qc.delete();

      @(posedge clk); #1;
      check("rnd b beat_cnt", 136'(cnt_b), 136'(exp_cnt_b[15:0]));
      check("rnd c beat_cnt", 136'(cnt_c), 136'(exp_cnt_c[7:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
